thread_regfile_mp: RTL and testbench
====================================

# thread_regfile_mp

Multi-threaded, multi-ported register file with an integrated busy scoreboard. It is the parametrised successor to the single-thread 16x28 register file in the thread datapath. It holds one register bank per hardware thread and provides NRD combinational read ports for a shared thread select. Two independent writeback ports serve the ALU (port A) and load/store (port B). Per-register busy bits let issue logic stall on outstanding writebacks.

## Interface
- NTHR, 4: hardware threads; one bank each; power of two ≥1
- DEPTH, 16: registers per bank; power of two ≥2; register 0 reads zero
- WIDTH, 28: register width in bits
- NRD, 2: read ports, 1..4
- BYPASS, 1: 1 = same-cycle write-to-read forwarding; 0 = writes visible next cycle only
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- rd_tid  in  TW=max(1,clog2(NTHR))  thread for all read ports
- rd_sel  in  NRD*AW (AW=clog2(DEPTH))  register index per port; port k at bits [k*AW +: AW]
- rd_data  out  NRD*WIDTH  read data per port
- rd_busy  out  NRD  busy bit of the register addressed on each port
- wa_en, wa_tid, wa_dst, wa_data  in  1/TW/AW/WIDTH  write port A (ALU)
- wb_en, wb_tid, wb_dst, wb_data  in  1/TW/AW/WIDTH  write port B (load)
- iss_en, iss_tid, iss_dst  in  1/TW/AW  issue: mark destination pending
- wr_collide  out  1  registered; high for one cycle after a cycle in which A and B wrote the same thread/register

## Operation
- Storage: NTHR×DEPTH×WIDTH data; NTHR×DEPTH busy bits.
- Writes to register 0 of any thread are ignored. Issue to register 0 is ignored. busy[t][0] is always 0.
- Write port A or B with en=1 and dst≠0: data[tid][dst] is updated at the edge and busy[tid][dst] is cleared.
- A and B target the same tid/dst in one cycle: port A data is stored, busy is cleared, and wr_collide=1 on the next cycle. Distinct targets are both written.
- Issue with iss_en=1 and dst≠0: busy[iss_tid][iss_dst] is set. If a writeback clears the same bit in the same cycle, set wins (the new producer is outstanding).
- Reads are combinational:
  - rd_data[k] = data[rd_tid][sel_k]; 0 if sel_k=0.
  - rd_busy[k] = busy[rd_tid][sel_k].
- BYPASS=1: if port A (else B) writes rd_tid/sel_k in the current cycle with sel_k≠0, rd_data[k] returns that write data. In the same case rd_busy[k] returns 0 unless a same-cycle issue targets the same register, in which case it returns 1.
- BYPASS=0: reads reflect state only; there is no combinational path from write or issue inputs to outputs.
- Indices are full-range (power-of-two sizes); no out-of-range case exists.

## Timing
- Reset (async assert, any time): all data=0, all busy=0, wr_collide=0. rd_data and rd_busy therefore show 0 while rst is high.
- Reset deassertion: the first edge after release is a normal edge.
- Read latency: 0 cycles (combinational).
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0.
- Issue-to-busy visible: next cycle.
- Writeback-to-busy cleared: next cycle; same cycle via bypass.
- wr_collide: exactly one cycle wide per colliding cycle. Consecutive collisions keep it high continuously.
- No handshake: all ports are always accepted. The scoreboard does not block writes; stalling is the issue logic's job.

## Test plan
- Reset: write nonzero values, then assert rst mid-cycle -> all rd_data=0 and rd_busy=0 immediately; wr_collide=0.
- Basic/thread isolation (NTHR=4): wa writes T1 R5=0xABCDEF1 -> next cycle, T1 R5 reads 0xABCDEF1; T0 R5 and T2 R5 read 0.
- Register 0: wa_dst=0 with 0xFFFFFFF, plus iss_dst=0 -> R0 reads 0 and busy 0 on every thread.
- Collision: wa (0x1111111) and wb (0x2222222) both target T2 R7 -> next cycle R7=0x1111111 and wr_collide=1 for one cycle. Then wa T2 R7 and wb T2 R8 -> both stored, wr_collide=0.
- Scoreboard:
  - Issue T0 R3 -> next cycle rd_busy=1.
  - wb writes T0 R3=0x0000042 in the same cycle as issue T0 R3 -> busy stays 1, data=0x42.
  - Later wb alone -> busy 0.
- Bypass: BYPASS=1, read T3 R9 while wa writes 0x5A5A5A5 to it -> same-cycle rd_data=0x5A5A5A5 and rd_busy=0. Repeat with BYPASS=0 -> old value this cycle, new value next cycle.

Source files
------------

// File: rtl/thread_regfile_mp.sv
// Multi-threaded register file: one bank per thread, NRD read ports, ALU/load writebacks, per-register busy scoreboard.
// Latency: reads are combinational; writes and busy updates land on the next rising edge, with optional same-cycle forwarding.
// Backpressure: none, every port is accepted every cycle; stalling on busy registers is the issue logic's responsibility.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   rd_tid, rd_sel, rd_data, rd_busy  shared-thread read ports (port k at [k*AW +: AW] / [k*WIDTH +: WIDTH])
//   wa_*                              ALU writeback port (wins on a same-register collision)
//   wb_*                              load/store writeback port
//   iss_*                             issue: mark destination busy
//   wr_collide                        registered flag, A and B wrote the same thread/register last cycle
module thread_regfile_mp #(
  parameter int NTHR   = 4,
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 28,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int TW    = (NTHR > 1) ? $clog2(NTHR) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TW-1:0]        rd_tid,
  input  logic [NRD*AW-1:0]    rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wa_en,
  input  logic [TW-1:0]        wa_tid,
  input  logic [AW-1:0]        wa_dst,
  input  logic [WIDTH-1:0]     wa_data,
  input  logic                 wb_en,
  input  logic [TW-1:0]        wb_tid,
  input  logic [AW-1:0]        wb_dst,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 iss_en,
  input  logic [TW-1:0]        iss_tid,
  input  logic [AW-1:0]        iss_dst,
  output logic                 wr_collide
);

  localparam bit BYP = (BYPASS != 0);

  logic [WIDTH-1:0] mem  [NTHR][DEPTH];
  logic [DEPTH-1:0] busy [NTHR];

  // Register 0 is hardwired: writes and issues aimed at it are dropped here.
  logic wa_act, wb_act, iss_act, same_tgt;
  assign wa_act   = wa_en  && (wa_dst  != '0);
  assign wb_act   = wb_en  && (wb_dst  != '0);
  assign iss_act  = iss_en && (iss_dst != '0);
  assign same_tgt = wa_act && wb_act && (wa_tid == wb_tid) && (wa_dst == wb_dst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTHR; t++) begin
        busy[t] <= '0;
        for (int r = 0; r < DEPTH; r++) begin
          mem[t][r] <= '0;
        end
      end
      wr_collide <= 1'b0;
    end else begin
      // Port B is applied first so port A overrides it on a shared target.
      if (wb_act) begin
        mem[wb_tid][wb_dst]  <= wb_data;
        busy[wb_tid][wb_dst] <= 1'b0;
      end
      if (wa_act) begin
        mem[wa_tid][wa_dst]  <= wa_data;
        busy[wa_tid][wa_dst] <= 1'b0;
      end
      // Issue applied last: a new producer outranks a retiring one.
      if (iss_act) begin
        busy[iss_tid][iss_dst] <= 1'b1;
      end
      wr_collide <= same_tgt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]    sel;
      logic [WIDTH-1:0] d;
      logic             b;
      sel = rd_sel[k*AW +: AW];
      d   = (sel == '0) ? '0 : mem[rd_tid][sel];
      b   = busy[rd_tid][sel];
      // Forwarding is suppressed during reset so outputs read as zero.
      if (BYP && !rst && (sel != '0)) begin
        if (wa_act && (wa_tid == rd_tid) && (wa_dst == sel)) begin
          d = wa_data;
          b = iss_act && (iss_tid == rd_tid) && (iss_dst == sel);
        end else if (wb_act && (wb_tid == rd_tid) && (wb_dst == sel)) begin
          d = wb_data;
          b = iss_act && (iss_tid == rd_tid) && (iss_dst == sel);
        end
      end
      rd_data[k*WIDTH +: WIDTH] = d;
      rd_busy[k]                = b;
    end
  end

endmodule

// File: tb/tb_thread_regfile_mp.sv
// Directed bench for thread_regfile_mp: one forwarding instance and one non-forwarding instance share all inputs.
module tb_thread_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_tid;
  logic [7:0]  rd_sel;
  logic [55:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wa_en, wb_en, iss_en;
  logic [1:0]  wa_tid, wb_tid, iss_tid;
  logic [3:0]  wa_dst, wb_dst, iss_dst;
  logic [27:0] wa_data, wb_data;
  logic        wr_collide, wr_collide_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thread_regfile_mp #(.NTHR(4), .DEPTH(16), .WIDTH(28), .NRD(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_tid(rd_tid), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_tid(wa_tid), .wa_dst(wa_dst), .wa_data(wa_data),
    .wb_en(wb_en), .wb_tid(wb_tid), .wb_dst(wb_dst), .wb_data(wb_data),
    .iss_en(iss_en), .iss_tid(iss_tid), .iss_dst(iss_dst), .wr_collide(wr_collide)
  );

  thread_regfile_mp #(.NTHR(4), .DEPTH(16), .WIDTH(28), .NRD(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_tid(rd_tid), .rd_sel(rd_sel), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wa_en(wa_en), .wa_tid(wa_tid), .wa_dst(wa_dst), .wa_data(wa_data),
    .wb_en(wb_en), .wb_tid(wb_tid), .wb_dst(wb_dst), .wb_data(wb_data),
    .iss_en(iss_en), .iss_tid(iss_tid), .iss_dst(iss_dst), .wr_collide(wr_collide_nb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0;
    wa_tid = 0; wb_tid = 0; iss_tid = 0;
    wa_dst = 0; wb_dst = 0; iss_dst = 0;
    wa_data = 0; wb_data = 0;
  endtask

  task automatic rd(input logic [1:0] t, input logic [3:0] s0, input logic [3:0] s1);
    rd_tid = t;
    rd_sel = {s1, s0};
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd(2'd0, 4'd5, 4'd9);
    repeat (2) step();
    chk("reset_data",     {8'h0, rd_data},    64'h0);
    chk("reset_busy",     {62'h0, rd_busy},   64'h0);
    chk("reset_collide",  {63'h0, wr_collide}, 64'h0);
    rst = 1'b0;

    // Thread isolation.
    step();
    wa_en = 1; wa_tid = 2'd1; wa_dst = 4'd5; wa_data = 28'hABCDEF1;
    step();
    idle();
    rd(2'd1, 4'd5, 4'd5);
    chk("t1r5_p0",    {36'h0, rd_data[27:0]},     64'hABCDEF1);
    chk("t1r5_p1",    {36'h0, rd_data[55:28]},    64'hABCDEF1);
    chk("t1r5_nb",    {36'h0, rd_data_nb[27:0]},  64'hABCDEF1);
    rd(2'd0, 4'd5, 4'd5);
    chk("t0r5_zero",  {36'h0, rd_data[27:0]},     64'h0);
    rd(2'd2, 4'd5, 4'd5);
    chk("t2r5_zero",  {36'h0, rd_data[27:0]},     64'h0);

    // Register 0 ignores writes and issues.
    step();
    wa_en = 1; wa_tid = 2'd1; wa_dst = 4'd0; wa_data = 28'hFFFFFFF;
    iss_en = 1; iss_tid = 2'd1; iss_dst = 4'd0;
    rd(2'd1, 4'd0, 4'd0);
    chk("r0_bypass_data", {36'h0, rd_data[27:0]}, 64'h0);
    step();
    idle();
    for (int t = 0; t < 4; t++) begin
      rd(t[1:0], 4'd0, 4'd0);
      chk($sformatf("r0_data_t%0d", t), {36'h0, rd_data[27:0]}, 64'h0);
      chk($sformatf("r0_busy_t%0d", t), {62'h0, rd_busy},       64'h0);
    end

    // Collision, then distinct targets.
    step();
    wa_en = 1; wa_tid = 2'd2; wa_dst = 4'd7; wa_data = 28'h1111111;
    wb_en = 1; wb_tid = 2'd2; wb_dst = 4'd7; wb_data = 28'h2222222;
    step();
    wa_data = 28'h3333333; wb_dst = 4'd8; wb_data = 28'h4444444;
    rd(2'd2, 4'd7, 4'd8);
    chk("collide_hi",    {63'h0, wr_collide},        64'h1);
    chk("collide_hi_nb", {63'h0, wr_collide_nb},     64'h1);
    chk("collide_r7_nb", {36'h0, rd_data_nb[27:0]},  64'h1111111);
    step();
    idle();
    rd(2'd2, 4'd7, 4'd8);
    chk("collide_lo",    {63'h0, wr_collide},        64'h0);
    chk("distinct_r7",   {36'h0, rd_data[27:0]},     64'h3333333);
    chk("distinct_r8",   {36'h0, rd_data[55:28]},    64'h4444444);

    // Scoreboard.
    step();
    iss_en = 1; iss_tid = 2'd0; iss_dst = 4'd3;
    rd(2'd0, 4'd3, 4'd3);
    chk("iss_not_yet_nb", {62'h0, rd_busy_nb}, 64'h0);
    step();
    idle();
    rd(2'd0, 4'd3, 4'd3);
    chk("iss_busy",    {62'h0, rd_busy},    64'h3);
    chk("iss_busy_nb", {62'h0, rd_busy_nb}, 64'h3);
    step();
    iss_en = 1; iss_tid = 2'd0; iss_dst = 4'd3;
    wb_en = 1; wb_tid = 2'd0; wb_dst = 4'd3; wb_data = 28'h0000042;
    rd(2'd0, 4'd3, 4'd3);
    chk("setwins_byp_busy", {62'h0, rd_busy},          64'h3);
    chk("setwins_byp_data", {36'h0, rd_data[27:0]},    64'h42);
    step();
    idle();
    rd(2'd0, 4'd3, 4'd3);
    chk("setwins_busy",  {62'h0, rd_busy_nb},          64'h3);
    chk("setwins_data",  {36'h0, rd_data_nb[27:0]},    64'h42);
    step();
    wb_en = 1; wb_tid = 2'd0; wb_dst = 4'd3; wb_data = 28'h0000055;
    rd(2'd0, 4'd3, 4'd3);
    chk("wb_byp_busy",    {62'h0, rd_busy},          64'h0);
    chk("wb_byp_data",    {36'h0, rd_data[27:0]},    64'h55);
    chk("wb_nb_old_busy", {62'h0, rd_busy_nb},       64'h3);
    chk("wb_nb_old_data", {36'h0, rd_data_nb[27:0]}, 64'h42);
    step();
    idle();
    rd(2'd0, 4'd3, 4'd3);
    chk("wb_clear_busy",  {62'h0, rd_busy_nb},       64'h0);

    // Forwarding versus no forwarding.
    step();
    wa_en = 1; wa_tid = 2'd3; wa_dst = 4'd9; wa_data = 28'h5A5A5A5;
    wb_en = 1; wb_tid = 2'd3; wb_dst = 4'd10; wb_data = 28'h0BEEF01;
    rd(2'd3, 4'd9, 4'd10);
    chk("byp_a_data",   {36'h0, rd_data[27:0]},     64'h5A5A5A5);
    chk("byp_b_data",   {36'h0, rd_data[55:28]},    64'h0BEEF01);
    chk("byp_busy",     {62'h0, rd_busy},           64'h0);
    chk("nobyp_old",    {36'h0, rd_data_nb[27:0]},  64'h0);
    step();
    idle();
    rd(2'd3, 4'd9, 4'd10);
    chk("nobyp_new",    {36'h0, rd_data_nb[27:0]},  64'h5A5A5A5);
    chk("nobyp_new_b",  {36'h0, rd_data_nb[55:28]}, 64'h0BEEF01);
    step();
    wa_en = 1; wa_tid = 2'd3; wa_dst = 4'd9; wa_data = 28'h0000777;
    iss_en = 1; iss_tid = 2'd3; iss_dst = 4'd9;
    rd(2'd3, 4'd9, 4'd10);
    chk("byp_iss_busy", {62'h0, rd_busy},           64'h1);

    // Mid-cycle reset with live state and a pending collide flag.
    step();
    wa_en = 1; wa_tid = 2'd1; wa_dst = 4'd4; wa_data = 28'h1234567;
    wb_en = 1; wb_tid = 2'd1; wb_dst = 4'd4; wb_data = 28'h7654321;
    iss_en = 0;
    step();
    idle();
    rd(2'd3, 4'd9, 4'd10);
    chk("pre_rst_busy",    {62'h0, rd_busy_nb},       64'h1);
    chk("pre_rst_collide", {63'h0, wr_collide},       64'h1);
    wa_en = 1; wa_tid = 2'd3; wa_dst = 4'd9; wa_data = 28'h0AAAAAA;
    rst = 1'b1;
    #1;
    chk("rst_data",     {8'h0, rd_data},            64'h0);
    chk("rst_busy",     {62'h0, rd_busy},           64'h0);
    chk("rst_data_nb",  {8'h0, rd_data_nb},         64'h0);
    chk("rst_busy_nb",  {62'h0, rd_busy_nb},        64'h0);
    chk("rst_collide",  {63'h0, wr_collide},        64'h0);
    idle();
    step();
    rst = 1'b0;
    step();
    rd(2'd1, 4'd4, 4'd4);
    chk("post_rst_t1r4", {36'h0, rd_data_nb[27:0]}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
